f9pcap_out_frame_fifo: RTL and testbench

- Store-and-forward frame buffer that sits directly downstream of the capture/wrap stage (the multicast-wrapped f9phdr frames).
- Accepts AXI-Stream-like beats with no backpressure and stores them. Only complete frames are released to the MAC/TX side through a valid/ready interface.
- A frame that overflows the buffer is dropped whole.
- buf_full_out feeds the upstream outbuf_full_in, so the upstream counts the loss in f9phdr.BufFullCnt_.

---
 rtl/f9pcap_out_frame_fifo.sv | 154 +++++++++++++++
 tb/tb_f9pcap_out_frame_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/f9pcap_out_frame_fifo.sv
// Store-and-forward frame buffer: beats arrive without backpressure, only committed
// frames become visible to the valid/ready output, and frames that overflow are dropped whole.
module f9pcap_out_frame_fifo #(
  parameter int DATA_WIDTH           = 64,
  parameter int ADDR_WIDTH           = 9,
  parameter int FULL_THRESHOLD_WORDS = 208,
  parameter int DROP_CNT_WIDTH       = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      i_valid_in,
  input  logic [DATA_WIDTH-1:0]     i_data_in,
  input  logic [DATA_WIDTH/8-1:0]   i_keep_in,
  input  logic                      i_last_in,
  output logic                      o_valid_out,
  input  logic                      o_ready_in,
  output logic [DATA_WIDTH-1:0]     o_data_out,
  output logic [DATA_WIDTH/8-1:0]   o_keep_out,
  output logic                      o_last_out,
  output logic                      buf_full_out,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_out
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int WORD_W     = 1 + KEEP_WIDTH + DATA_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int PW         = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} wr_state_e;

  wr_state_e                 state_q, state_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             wr_commit_q, wr_commit_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      buf_full_q, buf_full_d;
  logic                      we;

  logic [WORD_W-1:0]         mem_q [DEPTH];
  logic [WORD_W-1:0]         rdata_q;
  logic                      rvalid_q;
  logic                      rd_en;

  logic [WORD_W-1:0]         out_word_q, out_word_d;
  logic                      out_valid_q, out_valid_d;
  logic [WORD_W-1:0]         sk_word_q, sk_word_d;
  logic                      sk_valid_q, sk_valid_d;
  logic                      pop;
  logic [1:0]                held;

  logic [PW-1:0]             occ;
  logic                      full_w;

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign full_w     = (occ == PW'(DEPTH));
  assign buf_full_d = (32'(DEPTH) - 32'(occ)) < 32'(FULL_THRESHOLD_WORDS);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_cnt_d  = drop_cnt_q;
    we          = 1'b0;
    if (i_valid_in) begin
      case (state_q)
        S_IDLE, S_RECV: begin
          if (full_w) begin
            wr_ptr_d = wr_commit_q;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
            state_d = i_last_in ? S_IDLE : S_DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (i_last_in) begin
              wr_commit_d = wr_ptr_q + PW'(1);
              state_d     = S_IDLE;
            end else begin
              state_d = S_RECV;
            end
          end
        end
        S_DROP:  if (i_last_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Reads are issued only while head + skid + in-flight read leave a free slot,
  // so the skid register can never be overrun.
  assign pop  = out_valid_q && o_ready_in;
  assign held = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(rvalid_q);
  assign rd_en = (rd_ptr_q != wr_commit_q) && ((held < 2'd2) || ((held == 2'd2) && pop));
  assign rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;

  always_comb begin
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    sk_word_d   = sk_word_q;
    sk_valid_d  = sk_valid_q;
    if (!out_valid_q || pop) begin
      if (sk_valid_q) begin
        out_word_d  = sk_word_q;
        out_valid_d = 1'b1;
        sk_valid_d  = rvalid_q;
        if (rvalid_q) sk_word_d = rdata_q;
      end else begin
        out_valid_d = rvalid_q;
        if (rvalid_q) out_word_d = rdata_q;
      end
    end else if (rvalid_q) begin
      sk_valid_d = 1'b1;
      sk_word_d  = rdata_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {i_last_in, i_keep_in, i_data_in};
    if (rd_en) rdata_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      buf_full_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      sk_word_q   <= '0;
      sk_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_full_q  <= buf_full_d;
      rvalid_q    <= rd_en;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      sk_word_q   <= sk_word_d;
      sk_valid_q  <= sk_valid_d;
    end
  end

  assign o_valid_out                           = out_valid_q;
  assign {o_last_out, o_keep_out, o_data_out}  = out_word_q;
  assign buf_full_out                          = buf_full_q;
  assign drop_cnt_out                          = drop_cnt_q;

endmodule

// File: tb/tb_f9pcap_out_frame_fifo.sv
// Bench for f9pcap_out_frame_fifo: a 16-beat buffer with random frames, an expected-beat
// queue as reference model, and directed overflow / stall / reset scenarios.
module tb_f9pcap_out_frame_fifo;

  localparam int DW  = 64;
  localparam int KW  = DW / 8;
  localparam int AW  = 4;
  localparam int TH  = 6;
  localparam int DCW = 2;
  localparam int WW  = 1 + KW + DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid;
  logic [DW-1:0]  i_data;
  logic [KW-1:0]  i_keep;
  logic           i_last;
  logic           o_valid;
  logic           o_ready;
  logic [DW-1:0]  o_data;
  logic [KW-1:0]  o_keep;
  logic           o_last;
  logic           buf_full;
  logic [DCW-1:0] drop_cnt;

  f9pcap_out_frame_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FULL_THRESHOLD_WORDS(TH),
    .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .i_valid_in(i_valid),
    .i_data_in(i_data),
    .i_keep_in(i_keep),
    .i_last_in(i_last),
    .o_valid_out(o_valid),
    .o_ready_in(o_ready),
    .o_data_out(o_data),
    .o_keep_out(o_keep),
    .o_last_out(o_last),
    .buf_full_out(buf_full),
    .drop_cnt_out(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfer_cnt  = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  logic          rand_rdy = 1'b0;
  logic [WW-1:0] exp_q[$];
  logic          hold_chk = 1'b0;
  logic [WW-1:0] prev_word;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every transfer must match the head of the expected queue,
  // and a stalled beat must be presented unchanged on the next cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        chk("hold", {o_valid, o_last, o_keep, o_data}, {1'b1, prev_word});
      hold_chk  = o_valid && !o_ready;
      prev_word = {o_last, o_keep, o_data};
      if (o_valid && o_ready) begin
        xfer_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL extra_beat got=%0h exp=none", prev_word);
        end
        if (exp_q.size() > 0) chk("beat", prev_word, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) o_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                       input logic push);
    i_valid = 1'b1;
    i_data  = d;
    i_keep  = k;
    i_last  = l;
    if (push) exp_q.push_back({l, k, d});
  endtask

  task automatic drive_rand(input logic l, input logic push);
    drive({$urandom, $urandom}, KW'($urandom), l, push);
  endtask

  task automatic idle(input int n);
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n - 1) step();
  endtask

  task automatic send_frame(input int len, input logic push, input logic gap);
    for (int i = 0; i < len; i++) begin
      step();
      drive_rand(i == len - 1, push);
    end
    if (gap) idle(1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_keep = '0; i_last = 1'b0; o_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 80'(o_valid), 80'd0);
    chk("rst_word", 80'({o_last, o_keep, o_data}), 80'd0);
    chk("rst_full", 80'(buf_full), 80'd0);
    chk("rst_drop", 80'(drop_cnt), 80'd0);
    rst = 1'b0;
    idle(2);

    // 3-beat frame, first-beat latency and back-to-back output
    o_ready = 1'b1;
    xfer_cnt = 0; first_cyc = -1;
    step(); drive({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
    step(); drive({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
    step(); drive({$urandom, $urandom}, 8'h0F, 1'b1, 1'b1);
    idle(1);
    chk("lat_1", 80'(o_valid), 80'd0);
    step();
    chk("lat_2", 80'(o_valid), 80'd0);
    step();
    chk("lat_3", 80'(o_valid), 80'd1);
    wait_drain("drain_a", 50);
    idle(3);
    chk("a_xfers", 80'(xfer_cnt), 80'd3);
    chk("a_span", 80'(last_cyc - first_cyc), 80'd2);
    chk("a_drop", 80'(drop_cnt), 80'd0);

    // 12-beat frame with output stalled: buf_full tracks occupancy one cycle late
    o_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) chk("bf_before", 80'(buf_full), 80'd0);
      drive_rand(k == 12, 1'b1);
    end
    idle(1);
    chk("bf_after", 80'(buf_full), 80'd1);
    idle(6);
    chk("bf_release", 80'(buf_full), 80'd0);
    // Two beats of the committed frame now sit in the output stage: 10 remain in memory.
    send_frame(8, 1'b0, 1'b1);
    idle(3);
    chk("drop_8beat", 80'(drop_cnt), 80'd1);
    send_frame(6, 1'b1, 1'b1);
    idle(3);
    chk("fit_6beat", 80'(drop_cnt), 80'd1);
    send_frame(1, 1'b0, 1'b1);
    idle(2);
    chk("drop_single", 80'(drop_cnt), 80'd2);
    o_ready = 1'b1;
    wait_drain("drain_b", 200);
    idle(4);
    send_frame(2, 1'b1, 1'b1);
    wait_drain("after_single", 50);
    chk("b_drop", 80'(drop_cnt), 80'd2);

    // Self-overflowing frames from an empty buffer, counter saturation
    o_ready = 1'b0;
    idle(4);
    send_frame(20, 1'b0, 1'b1);
    idle(3);
    chk("drop_20a", 80'(drop_cnt), 80'd3);
    chk("bf_revert", 80'(buf_full), 80'd0);
    send_frame(20, 1'b0, 1'b1);
    idle(3);
    chk("drop_sat", 80'(drop_cnt), 80'd3);
    o_ready = 1'b1;
    send_frame(1, 1'b1, 1'b1);
    wait_drain("after_drop", 50);
    idle(4);

    // 40 back-to-back 3-beat frames, pointers wrap repeatedly
    xfer_cnt = 0; first_cyc = -1;
    for (int f = 0; f < 40; f++) send_frame(3, 1'b1, 1'b0);
    idle(1);
    wait_drain("drain_d", 300);
    idle(3);
    chk("d_xfers", 80'(xfer_cnt), 80'd120);
    chk("d_span", 80'(last_cyc - first_cyc), 80'd119);
    chk("d_drop", 80'(drop_cnt), 80'd3);

    // Random ready while frames stream in and drain
    for (int b = 0; b < 4; b++) begin
      int beats = 0;
      rand_rdy = 1'b1;
      while (beats < 12) begin
        int len = $urandom_range(1, 4);
        send_frame(len, 1'b1, 1'($urandom_range(0, 1)));
        beats += len;
      end
      idle(1);
      wait_drain("drain_rand", 2000);
      rand_rdy = 1'b0;
      o_ready  = 1'b1;
      idle(3);
    end
    chk("e_drop", 80'(drop_cnt), 80'd3);

    // Reset mid-frame with two committed frames buffered
    o_ready = 1'b0;
    send_frame(3, 1'b1, 1'b1);
    send_frame(4, 1'b1, 1'b1);
    step(); drive_rand(1'b0, 1'b0);
    step(); drive_rand(1'b0, 1'b0);
    step();
    rst = 1'b1;
    i_valid = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_valid", 80'(o_valid), 80'd0);
    chk("mid_rst_drop", 80'(drop_cnt), 80'd0);
    chk("mid_rst_full", 80'(buf_full), 80'd0);
    rst = 1'b0;
    o_ready = 1'b1;
    idle(2);
    send_frame(3, 1'b1, 1'b1);
    wait_drain("after_rst", 50);
    idle(4);
    chk("f_quiet", 80'(o_valid), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
